hud_reg_scheduler: RTL and testbench
====================================

# hud_reg_scheduler

Sequencer that keeps the text-mode HUD register bank (the "Score|" / two-digit score / "LIFE|" / heart-icon words) in sync with game state. It samples `score_num` and `life_num` once per frame on `frame_start` and converts the score to two decimal digits sequentially. It then pushes only the changed 32-bit font words over a valid/ready write port into the text controller's register file. A full 7-word rewrite is issued after reset or on request.

## Interface
- No parameters.
- axi_aclk  in  1  system clock; all logic on rising edge
- axi_aresetn  in  1  asynchronous, active-low reset
- score_num  in  8  current score, binary
- life_num  in  2  lives lost (0..3)
- frame_start  in  1  one-cycle pulse at start of vertical blank
- force_refresh  in  1  one-cycle pulse requesting a full 7-word rewrite
- wr_valid  out  1  write request
- wr_ready  in  1  register file accepts the write
- wr_addr  out  3  word index 0..6
- wr_data  out  32  font word
- busy  out  1  high from sample until the last write handshake

## Operation
- Word contents, fixed:
  - w0 = 0x726F6353
  - w1 = 0x00007C65
  - w2 = {4'h3, ones, 4'h3, tens, 16'h0000}
  - w3 = 0x00000000
  - w4 = 0x4546494C
  - w5 = 0x0000007C
  - w6 by life: 0→0x00838383, 1→0x00008383, 2→0x00000083, 3→0x00000000
- Score saturation: `sat = (score_num > 99) ? 99 : score_num`.
- Registered state: `last_sat` (7b), `last_life` (2b), `full_pend` (1b). Reset values are 0, 0 and 1.
- `force_refresh` sets `full_pend` in any state. A pulse in the same cycle as the sample is taken for that frame.
- States and transitions:
  - IDLE → CONVERT on `frame_start` if `full_pend` or `sat != last_sat` or `life_num != last_life`. On this edge:
    - latch `sat` into `rem`, clear `tens`.
    - latch the write mask: full = all 7 words; otherwise w2 if the score changed, w6 if life changed.
    - update `last_sat`/`last_life`, clear `full_pend`.
  - IDLE with `frame_start` and nothing changed: no action; busy stays 0.
  - CONVERT: if `rem >= 10`, then `rem -= 10` and `tens += 1`; else go to WRITE with `ones = rem`. One subtraction per cycle.
  - WRITE: issue the masked words in ascending address order. Move to the next word on the handshake edge (`wr_valid & wr_ready`). After the last handshake go to IDLE.
- `frame_start` while busy is ignored. Pending changes are caught on the next frame by comparison against `last_*`.
- Inputs are sampled only on the IDLE sample edge. Changes mid-sequence do not alter words already latched.

## Timing
- Reset values: wr_valid=0, wr_addr=0, wr_data=0, busy=0, state=IDLE. Reset takes effect asynchronously, including mid-write.
- busy rises the cycle after the sample edge and falls the cycle after the final handshake.
- CONVERT lasts tens+1 cycles (1..10).
- wr_valid rises on the first WRITE cycle and stays high with no bubbles between words.
- wr_addr and wr_data are stable while `wr_valid & !wr_ready`. wr_valid is never withdrawn without a handshake, except on reset.
- wr_data is 0 whenever wr_valid is 0.
- Best-case latency, sample edge to first handshake, with wr_ready held high: 2 + tens cycles.
- Full rewrite with wr_ready held high: 7 consecutive handshake cycles.

## Test plan
- Release reset; score=0, life=0; pulse frame_start; wr_ready=1 → 7 writes, addr 0..6, data 726F6353, 00007C65, 30300000, 00000000, 4546494C, 0000007C, 00838383; then busy=0.
- score=47 → next frame_start: CONVERT for 5 cycles, then one write addr 2 data 0x37340000; no other writes.
- score=200 → write addr 2 data 0x39390000. Then score=150 + frame_start → no write, busy stays 0.
- score 47→5 and life 0→2 in the same frame → addr 2 data 0x35300000, then addr 6 data 0x00000083, back to back.
- wr_ready low for 3 cycles during a write → valid/addr/data held constant. force_refresh pulsed while busy → the next frame_start with no state change still produces the full 7-word rewrite.
- axi_aresetn asserted during word 3 of a full rewrite → wr_valid and busy go 0 immediately. After release, frame_start → full 7-word rewrite from addr 0.

Source files
------------

// File: rtl/hud_reg_scheduler.sv
// HUD register-bank sequencer: samples score/life once per frame, converts the
// score to two decimal digits by repeated subtraction, then writes changed font words.
module hud_reg_scheduler (
  input  logic        axi_aclk,
  input  logic        axi_aresetn,
  input  logic [7:0]  score_num,
  input  logic [1:0]  life_num,
  input  logic        frame_start,
  input  logic        force_refresh,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [2:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    WRITE   = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [6:0]  last_sat;
  logic [1:0]  last_life;
  logic        full_pend;
  logic [6:0]  rem;
  logic [3:0]  tens;
  logic [3:0]  ones;
  logic [6:0]  mask;
  logic [2:0]  cur;

  logic [6:0]  sat;
  logic        score_chg;
  logic        life_chg;
  logic        full_now;
  logic        sample;
  logic        hs;
  logic [6:0]  mask_left;

  function automatic logic [2:0] lowest(input logic [6:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  assign sat       = (score_num > 8'd99) ? 7'd99 : score_num[6:0];
  assign score_chg = (sat != last_sat);
  assign life_chg  = (life_num != last_life);
  // A refresh request arriving on the sample edge belongs to this frame.
  assign full_now  = full_pend | force_refresh;
  assign sample    = (state == IDLE) && frame_start && (full_now || score_chg || life_chg);
  assign hs        = wr_valid && wr_ready;
  assign mask_left = mask & ~(7'd1 << cur);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (sample) state_n = CONVERT;
      CONVERT: if (rem < 7'd10) state_n = WRITE;
      WRITE:   if (hs && (mask_left == 7'd0)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state     <= IDLE;
      last_sat  <= 7'd0;
      last_life <= 2'd0;
      full_pend <= 1'b1;
      rem       <= 7'd0;
      tens      <= 4'd0;
      ones      <= 4'd0;
      mask      <= 7'd0;
      cur       <= 3'd0;
    end else begin
      state <= state_n;

      if (sample) begin
        rem       <= sat;
        tens      <= 4'd0;
        mask      <= full_now ? 7'h7F : {life_chg, 3'b000, score_chg, 2'b00};
        last_sat  <= sat;
        last_life <= life_num;
        full_pend <= 1'b0;
      end else if (force_refresh) begin
        full_pend <= 1'b1;
      end

      if (state == CONVERT) begin
        if (rem >= 7'd10) begin
          rem  <= rem - 7'd10;
          tens <= tens + 4'd1;
        end else begin
          ones <= rem[3:0];
          cur  <= lowest(mask);
        end
      end

      if ((state == WRITE) && hs) begin
        mask <= mask_left;
        cur  <= lowest(mask_left);
      end
    end
  end

  always_comb begin
    wr_valid = (state == WRITE);
    busy     = (state != IDLE);
    wr_addr  = 3'd0;
    wr_data  = 32'h0000_0000;
    if (wr_valid) begin
      wr_addr = cur;
      case (cur)
        3'd0:    wr_data = 32'h726F_6353;
        3'd1:    wr_data = 32'h0000_7C65;
        3'd2:    wr_data = {4'h3, ones, 4'h3, tens, 16'h0000};
        3'd3:    wr_data = 32'h0000_0000;
        3'd4:    wr_data = 32'h4546_494C;
        3'd5:    wr_data = 32'h0000_007C;
        3'd6: begin
          case (last_life)
            2'd0:    wr_data = 32'h0083_8383;
            2'd1:    wr_data = 32'h0000_8383;
            2'd2:    wr_data = 32'h0000_0083;
            default: wr_data = 32'h0000_0000;
          endcase
        end
        default: wr_data = 32'h0000_0000;
      endcase
    end
  end

endmodule

// File: tb/tb_hud_reg_scheduler.sv
// Scoreboard bench for hud_reg_scheduler: a frame-level model predicts the
// write stream; a negedge monitor pops and compares each handshake.
module tb_hud_reg_scheduler;

  logic        axi_aclk = 1'b0;
  logic        axi_aresetn = 1'b0;
  logic [7:0]  score_num = 8'd0;
  logic [1:0]  life_num = 2'd0;
  logic        frame_start = 1'b0;
  logic        force_refresh = 1'b0;
  logic        wr_valid;
  logic        wr_ready = 1'b1;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy;

  hud_reg_scheduler dut (
    .axi_aclk      (axi_aclk),
    .axi_aresetn   (axi_aresetn),
    .score_num     (score_num),
    .life_num      (life_num),
    .frame_start   (frame_start),
    .force_refresh (force_refresh),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .busy          (busy)
  );

  always #5 axi_aclk = ~axi_aclk;

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] data;
    bit          last;
    int          tens;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   hs_count = 0;
  bit   rand_ready = 0;

  // reference model state
  int   m_last_sat = 0;
  int   m_last_life = 0;
  bit   m_pend = 1;
  bit   m_busy = 0;
  int   sample_cyc = 0;
  int   last_hs_cyc = 0;
  bit   ready_ok = 0;
  bit   first_pending = 0;
  bit   stalled = 0;
  logic [2:0]  st_addr;
  logic [31:0] st_data;
  int   s;
  bit   full, sc, lc;
  exp_t e;

  always @(posedge axi_aclk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_of(input int a, input int sv, input int life);
    case (a)
      0: return 32'h726F6353;
      1: return 32'h00007C65;
      2: return {4'h3, 4'(sv % 10), 4'h3, 4'(sv / 10), 16'h0000};
      3: return 32'h00000000;
      4: return 32'h4546494C;
      5: return 32'h0000007C;
      default: begin
        if (life == 0) return 32'h00838383;
        if (life == 1) return 32'h00008383;
        if (life == 2) return 32'h00000083;
        return 32'h00000000;
      end
    endcase
  endfunction

  // Model + monitor: at each negedge, predict a sample on the coming edge and
  // check any handshake that the coming edge will complete.
  always @(negedge axi_aclk) begin
    if (!axi_aresetn) begin
      stalled = 0;
    end else begin
      check("busy", busy, m_busy);

      if (frame_start && !m_busy) begin
        s    = (score_num > 99) ? 99 : int'(score_num);
        full = m_pend || force_refresh;
        sc   = (s != m_last_sat);
        lc   = (int'(life_num) != m_last_life);
        if (full || sc || lc) begin
          for (int a = 0; a < 7; a++) begin
            if (full || (a == 2 && sc) || (a == 6 && lc)) begin
              e.addr = 3'(a);
              e.data = word_of(a, s, int'(life_num));
              e.last = 0;
              e.tens = s / 10;
              q.push_back(e);
            end
          end
          q[q.size()-1].last = 1;
          m_last_sat    = s;
          m_last_life   = int'(life_num);
          m_pend        = 0;
          m_busy        = 1;
          sample_cyc    = cyc;
          ready_ok      = 1;
          first_pending = 1;
        end
      end else if (force_refresh) begin
        m_pend = 1;
      end
      if (m_busy && !wr_ready) ready_ok = 0;

      if (stalled) begin
        check("stall_valid", wr_valid, 1);
        check("stall_addr", wr_addr, st_addr);
        check("stall_data", wr_data, st_data);
      end
      if (!wr_valid) check("idle_data", wr_data, 0);
      stalled = wr_valid && !wr_ready;
      st_addr = wr_addr;
      st_data = wr_data;

      if (wr_valid && wr_ready) begin
        hs_count++;
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0d data %h expected none", wr_addr, wr_data);
        end else begin
          e = q.pop_front();
          check("wr_addr", wr_addr, e.addr);
          check("wr_data", wr_data, e.data);
          if (ready_ok) begin
            if (first_pending) check("latency", cyc - sample_cyc, 2 + e.tens);
            else check("back_to_back", cyc - last_hs_cyc, 1);
          end
          first_pending = 0;
          last_hs_cyc = cyc;
          if (e.last) m_busy = 0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge axi_aclk);
      #1;
      if (rand_ready) wr_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic pulse_frame(input int sc_in, input int lf, input bit frc);
    score_num     = 8'(sc_in);
    life_num      = 2'(lf);
    frame_start   = 1'b1;
    force_refresh = frc;
    tick(1);
    frame_start   = 1'b0;
    force_refresh = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (q.size() == 0 && !m_busy && !busy) break;
      tick(1);
    end
    check("idle_reached", busy, 0);
    check("queue_drained", q.size(), 0);
  endtask

  task automatic model_reset();
    q.delete();
    m_last_sat  = 0;
    m_last_life = 0;
    m_pend      = 1;
    m_busy      = 0;
    first_pending = 0;
  endtask

  int hs_base;

  initial begin
    tick(3);
    check("rst_valid", wr_valid, 0);
    check("rst_addr", wr_addr, 0);
    check("rst_data", wr_data, 0);
    check("rst_busy", busy, 0);
    axi_aresetn = 1'b1;
    tick(2);

    // Initial full rewrite
    hs_base = hs_count;
    pulse_frame(0, 0, 0);
    wait_idle(100);
    check("full_count", hs_count - hs_base, 7);

    // Score-only updates, saturation, and a no-change frame
    pulse_frame(47, 0, 0);
    wait_idle(100);
    pulse_frame(200, 0, 0);
    wait_idle(100);
    hs_base = hs_count;
    pulse_frame(150, 0, 0);
    tick(6);
    check("nochange_busy", busy, 0);
    check("nochange_writes", hs_count - hs_base, 0);

    // Score and life change in one frame
    pulse_frame(5, 2, 0);
    wait_idle(100);

    // Stall with wr_ready low, and force_refresh while busy
    wr_ready = 1'b0;
    pulse_frame(33, 2, 0);
    tick(1);
    pulse_frame(33, 2, 1);
    for (int k = 0; k < 30 && !wr_valid; k++) tick(1);
    check("stall_reached", wr_valid, 1);
    tick(3);
    wr_ready = 1'b1;
    wait_idle(100);
    hs_base = hs_count;
    pulse_frame(33, 2, 0);
    wait_idle(100);
    check("forced_count", hs_count - hs_base, 7);

    // Asynchronous reset during word 3 of a full rewrite
    pulse_frame(33, 2, 1);
    for (int k = 0; k < 40 && !(wr_valid && wr_addr == 3'd3); k++) tick(1);
    check("reached_word3", wr_addr, 3);
    #2 axi_aresetn = 1'b0;
    #1;
    check("areset_valid", wr_valid, 0);
    check("areset_busy", busy, 0);
    check("areset_addr", wr_addr, 0);
    model_reset();
    tick(2);
    axi_aresetn = 1'b1;
    tick(1);
    hs_base = hs_count;
    pulse_frame(0, 0, 0);
    wait_idle(100);
    check("post_reset_count", hs_count - hs_base, 7);

    // Randomized frames, including frames that arrive while busy
    rand_ready = 1;
    for (int it = 0; it < 80; it++) begin
      pulse_frame($urandom_range(0, 255), $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
      tick($urandom_range(0, 14));
    end
    rand_ready = 0;
    wr_ready = 1'b1;
    wait_idle(500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
